// File: rtl/wb_mul_pkg.sv
// ============================================================================
// wb_mul_pkg : shared definitions for the iterative WB multiplier peripheral
// Rev 2.0    : signed mode, status register, sticky done, maskable irq
// ============================================================================
`default_nettype none

package wb_mul_pkg;

  localparam logic [7:0] ADR_MC     = 8'h00;
  localparam logic [7:0] ADR_MP     = 8'h04;
  localparam logic [7:0] ADR_P0     = 8'h08;
  localparam logic [7:0] ADR_P1     = 8'h0C;
  localparam logic [7:0] ADR_CTRL   = 8'h10;
  localparam logic [7:0] ADR_STATUS = 8'h14;

  localparam int CTRL_SIGNED_BIT = 0;
  localparam int CTRL_IRQEN_BIT  = 1;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  localparam logic [31:0] BAD_DATA_DEFAULT = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } eng_state_e;

  // Byte-lane merge of a bus write into an existing register value
  function automatic logic [31:0] apply_sel(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[i*8 +: 8] = sel[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_iter_core.sv
// ============================================================================
// mul_iter_core : radix-2^BPC shift-add multiplier, magnitude + sign fix-up
// Rev 2.0       : signed operands, restartable from any state
// ============================================================================
`default_nettype none

module mul_iter_core
  import wb_mul_pkg::*;
#(
  parameter int OP_W = 32,
  parameter int BPC  = 1
) (
  input  logic              sys_clk,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic              sgn,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*OP_W-1:0] p
);

  localparam int PW    = 2 * OP_W;
  localparam int N     = OP_W / BPC;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  eng_state_e       state_q, state_d;
  logic [OP_W-1:0]  a_q, a_d, b_q, b_d, mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d, mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_q, sgn_d, neg_q, neg_d;
  logic [OP_W-1:0]  mag_a, mag_b;

  always_ff @(posedge sys_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // start wins from every state so an in-flight operation is simply abandoned
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = PREP;
    end else begin
      case (state_q)
        PREP:    state_d = ITER;
        ITER:    state_d = (cnt_q == CNT_LAST) ? FIX : ITER;
        FIX:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign mag_a = (sgn_q & a_q[OP_W-1]) ? (~a_q + OP_W'(1)) : a_q;
  assign mag_b = (sgn_q & b_q[OP_W-1]) ? (~b_q + OP_W'(1)) : b_q;

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start) begin
      a_d   = a;
      b_d   = b;
      sgn_d = sgn;
    end else begin
      case (state_q)
        PREP: begin
          mcand_d  = {{OP_W{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = sgn_q & (a_q[OP_W-1] ^ b_q[OP_W-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end
        ITER: begin
          acc_d    = acc_q + mcand_q * PW'(mplier_q[BPC-1:0]);
          mcand_d  = mcand_q << BPC;
          mplier_d = mplier_q >> BPC;
          cnt_d    = cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == FIX) & ~start;
    p    = neg_q ? (~acc_q + PW'(1)) : acc_q;
  end

endmodule

`default_nettype wire

// File: rtl/wb_mul_iter_periph.sv
// ============================================================================
// wb_mul_iter_periph : Wishbone slave wrapper around mul_iter_core
// Rev 2.0            : CTRL/STATUS registers, held product reads, done irq
// ============================================================================
`default_nettype none

module wb_mul_iter_periph
  import wb_mul_pkg::*;
#(
  parameter int          OP_W     = 32,
  parameter int          BPC      = 1,
  parameter logic [31:0] BAD_DATA = BAD_DATA_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [2:0]  irq
);

  logic [31:0]       mc_q, mc_d, mp_q, mp_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [63:0]       p_q, p_d, p_ext;
  logic              done_q, done_d, ack_q, ack_d, op_sgn_q, op_sgn_d;
  logic              valid, p_rd, accept, wr, start, w1c;
  logic              core_busy, core_done;
  logic [2*OP_W-1:0] core_p;
  logic [7:0]        adr;
  logic              unused_adr;

  assign adr        = wbs_adr_i[7:0];
  assign unused_adr = &{1'b0, wbs_adr_i[31:8]};
  assign valid      = wbs_stb_i & wbs_cyc_i;
  assign p_rd       = ~wbs_we_i & ((adr == ADR_P0) | (adr == ADR_P1));
  // product reads stall while the engine runs; everything else takes one cycle
  assign accept     = valid & ~ack_q & ~(p_rd & core_busy);
  assign wr         = accept & wbs_we_i;
  assign start      = wr & (adr == ADR_MP);
  assign w1c        = wr & (adr == ADR_STATUS) & wbs_sel_i[0] & wbs_dat_i[STATUS_DONE_BIT];

  mul_iter_core #(
    .OP_W (OP_W),
    .BPC  (BPC)
  ) u_core (
    .sys_clk  (sys_clk),
    .wb_rst_i (wb_rst_i),
    .start    (start),
    .sgn      (ctrl_q[CTRL_SIGNED_BIT]),
    .a        (mc_q[OP_W-1:0]),
    .b        (mp_d[OP_W-1:0]),
    .busy     (core_busy),
    .done     (core_done),
    .p        (core_p)
  );

  generate
    if (OP_W == 32) begin : g_ext_none
      assign p_ext = core_p;
    end else begin : g_ext_fill
      assign p_ext = {{(64 - 2*OP_W){op_sgn_q & core_p[2*OP_W-1]}}, core_p};
    end
  endgenerate

  always_ff @(posedge sys_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      mc_q     <= '0;
      mp_q     <= '0;
      ctrl_q   <= '0;
      p_q      <= '0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      op_sgn_q <= 1'b0;
    end else begin
      mc_q     <= mc_d;
      mp_q     <= mp_d;
      ctrl_q   <= ctrl_d;
      p_q      <= p_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      op_sgn_q <= op_sgn_d;
    end
  end

  always_comb begin
    mc_d     = mc_q;
    mp_d     = mp_q;
    ctrl_d   = ctrl_q;
    ack_d    = accept;
    op_sgn_d = start ? ctrl_q[CTRL_SIGNED_BIT] : op_sgn_q;
    p_d      = core_done ? p_ext : p_q;
    if (wr && adr == ADR_MC) mc_d = apply_sel(mc_q, wbs_dat_i, wbs_sel_i);
    if (wr && adr == ADR_MP) mp_d = apply_sel(mp_q, wbs_dat_i, wbs_sel_i);
    if (wr && adr == ADR_CTRL && wbs_sel_i[0]) ctrl_d = wbs_dat_i[1:0];
    // a new start clears done; a completion beats a same-edge W1C
    done_d = done_q;
    if (w1c)       done_d = 1'b0;
    if (core_done) done_d = 1'b1;
    if (start)     done_d = 1'b0;
  end

  always_comb begin
    case (adr)
      ADR_MC:     wbs_dat_o = mc_q;
      ADR_MP:     wbs_dat_o = mp_q;
      ADR_P0:     wbs_dat_o = p_q[31:0];
      ADR_P1:     wbs_dat_o = p_q[63:32];
      ADR_CTRL:   wbs_dat_o = {30'd0, ctrl_q};
      ADR_STATUS: wbs_dat_o = {30'd0, done_q, core_busy};
      default:    wbs_dat_o = BAD_DATA;
    endcase
  end

  assign wbs_ack_o = ack_q;
  assign irq       = {2'b00, done_q & ctrl_q[CTRL_IRQEN_BIT]};

endmodule

`default_nettype wire

// File: tb/tb_wb_mul_iter_periph.sv
// ============================================================================
// tb_wb_mul_iter_periph : directed + random checks on three parameterisations
// Rev 2.0
// ============================================================================
`default_nettype none

module tb_wb_mul_iter_periph;

  logic        sys_clk = 1'b0;
  logic        wb_rst_i;
  logic        stb_v [3];
  logic        we;
  logic [3:0]  sel;
  logic [31:0] wdat, adr;
  logic        ack_v [3];
  logic [31:0] rdat_v [3];
  logic [2:0]  irq_v [3];

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int last_ack;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

  wb_mul_iter_periph #(.OP_W(32), .BPC(1)) u_dut32 (
    .sys_clk(sys_clk), .wb_rst_i(wb_rst_i), .wbs_stb_i(stb_v[0]), .wbs_cyc_i(stb_v[0]),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr),
    .wbs_ack_o(ack_v[0]), .wbs_dat_o(rdat_v[0]), .irq(irq_v[0]));

  wb_mul_iter_periph #(.OP_W(8), .BPC(2)) u_dut8 (
    .sys_clk(sys_clk), .wb_rst_i(wb_rst_i), .wbs_stb_i(stb_v[1]), .wbs_cyc_i(stb_v[1]),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr),
    .wbs_ack_o(ack_v[1]), .wbs_dat_o(rdat_v[1]), .irq(irq_v[1]));

  wb_mul_iter_periph #(.OP_W(16), .BPC(4)) u_dut16 (
    .sys_clk(sys_clk), .wb_rst_i(wb_rst_i), .wbs_stb_i(stb_v[2]), .wbs_cyc_i(stb_v[2]),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr),
    .wbs_ack_o(ack_v[2]), .wbs_dat_o(rdat_v[2]), .irq(irq_v[2]));

  function automatic int opw_of(input int d);
    return (d == 0) ? 32 : (d == 1) ? 8 : 16;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 32 / 1 + 2 : (d == 1) ? 8 / 2 + 2 : 16 / 4 + 2;
  endfunction

  // Exact product of the low w bits of each operand, as a 64-bit value
  function automatic logic [63:0] ref_p(input int w, input bit s,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, ua, ub;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    if (s && ua[w-1]) ua = ua | ~mask;
    if (s && ub[w-1]) ub = ub | ~mask;
    return ua * ub;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic xfer(input int d, input logic w, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] s, output logic [31:0] rd);
    we = w; adr = {24'd0, a}; wdat = wd; sel = s; stb_v[d] = 1'b1;
    last_ack = -1;
    rd = '0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (ack_v[d]) begin
        last_ack = cyc_cnt;
        rd = rdat_v[d];
        break;
      end
    end
    if (last_ack < 0) begin
      checks++;
      errors++;
      $error("FAIL ack_timeout dut=%0d adr=%h observed=no_ack expected=ack", d, a);
    end else begin
      tick();
      chk("ack_single_pulse", {63'd0, ack_v[d]}, 64'd0);
    end
    stb_v[d] = 1'b0;
  endtask

  task automatic wr(input int d, input logic [7:0] a, input logic [31:0] v);
    logic [31:0] dummy;
    xfer(d, 1'b1, a, v, 4'hF, dummy);
  endtask

  task automatic rd_chk(input int d, input logic [7:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    xfer(d, 1'b0, a, 32'd0, 4'hF, v);
    chk(tag, {32'd0, v}, {32'd0, exp});
  endtask

  task automatic wait_irq(input int d, input int c0, input string tag);
    int seen = -1;
    for (int i = 0; i < lat_of(d) + 20; i++) begin
      if (irq_v[d][0]) begin
        seen = cyc_cnt;
        break;
      end
      tick();
    end
    chk({tag, "_latency"}, 64'(seen - c0), 64'(lat_of(d)));
  endtask

  task automatic run_op(input int d, input bit s, input logic [31:0] mc,
                        input logic [31:0] mp, input string tag);
    logic [63:0] e;
    int c0;
    e = ref_p(opw_of(d), s, mc, mp);
    wr(d, 8'h10, {30'd0, 1'b1, s});
    wr(d, 8'h00, mc);
    wr(d, 8'h04, mp);
    c0 = last_ack;
    wait_irq(d, c0, tag);
    rd_chk(d, 8'h14, 32'h2, {tag, "_status"});
    rd_chk(d, 8'h08, e[31:0], {tag, "_p0"});
    rd_chk(d, 8'h0C, e[63:32], {tag, "_p1"});
    rd_chk(d, 8'h00, mc, {tag, "_mc_rb"});
  endtask

  initial begin
    logic [31:0] v, mc, mp;
    logic [63:0] e;
    int c0, c1, irq_seen;
    bit s;

    stb_v = '{1'b0, 1'b0, 1'b0};
    we = 1'b0; sel = 4'h0; wdat = '0; adr = '0;
    wb_rst_i = 1'b1;
    repeat (3) tick();
    wb_rst_i = 1'b0;
    tick();

    // reset state
    chk("rst_ack", {63'd0, ack_v[0]}, 64'd0);
    chk("rst_irq", {61'd0, irq_v[0]}, 64'd0);
    rd_chk(0, 8'h00, 32'd0, "rst_mc");
    rd_chk(0, 8'h04, 32'd0, "rst_mp");
    rd_chk(0, 8'h08, 32'd0, "rst_p0");
    rd_chk(0, 8'h10, 32'd0, "rst_ctrl");
    rd_chk(0, 8'h14, 32'd0, "rst_status");

    // unmapped space and byte enables
    rd_chk(0, 8'h18, 32'hDEADBEEF, "unmapped_rd");
    wr(0, 8'h40, 32'h12345678);
    rd_chk(0, 8'h40, 32'hDEADBEEF, "unmapped_wr_ignored");
    wr(0, 8'h00, 32'h11223344);
    xfer(0, 1'b1, 8'h00, 32'hAABBCCDD, 4'b0101, v);
    rd_chk(0, 8'h00, 32'h11BB33DD, "mc_bytesel");
    wr(0, 8'h10, 32'hFFFFFFFF);
    rd_chk(0, 8'h10, 32'h3, "ctrl_mask");

    // directed arithmetic corners
    run_op(0, 1'b0, 32'd7, 32'd6, "u_7x6");
    run_op(0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, "u_max");
    run_op(0, 1'b1, 32'hFFFFFFFB, 32'd3, "s_m5x3");
    run_op(0, 1'b1, 32'h80000000, 32'h80000000, "s_minxmin");

    // irq level and W1C
    chk("irq_after_done", {61'd0, irq_v[0]}, 64'd1);
    wr(0, 8'h14, 32'h2);
    chk("irq_after_w1c", {61'd0, irq_v[0]}, 64'd0);
    rd_chk(0, 8'h14, 32'h0, "status_after_w1c");

    // product read stalls until the cycle after done
    wr(0, 8'h10, 32'h2);
    wr(0, 8'h00, 32'h1234);
    wr(0, 8'h04, 32'h5678);
    c0 = last_ack;
    xfer(0, 1'b0, 8'h08, 32'd0, 4'hF, v);
    chk("held_rd_ack_cycle", 64'(last_ack - c0), 64'(lat_of(0) + 1));
    chk("held_rd_data", {32'd0, v}, 64'h1234 * 64'h5678);

    // W1C landing on the completion edge loses
    wr(0, 8'h04, 32'h9);
    c0 = last_ack;
    while (cyc_cnt < c0 + lat_of(0) - 1) tick();
    wr(0, 8'h14, 32'h2);
    chk("w1c_race_ack_edge", 64'(last_ack - c0), 64'(lat_of(0)));
    chk("w1c_race_irq", {61'd0, irq_v[0]}, 64'd1);
    rd_chk(0, 8'h14, 32'h2, "w1c_race_status");

    // restart mid-operation
    wr(0, 8'h00, 32'h000ABCDE);
    wr(0, 8'h04, 32'h00009999);
    c0 = last_ack;
    irq_seen = 0;
    while (cyc_cnt < c0 + 7) begin
      irq_seen |= int'(irq_v[0][0]);
      tick();
    end
    wr(0, 8'h00, 32'd5);
    wr(0, 8'h04, 32'd2);
    c1 = last_ack;
    chk("abort_no_early_irq", 64'(irq_seen), 64'd0);
    wait_irq(0, c1, "abort_restart");
    rd_chk(0, 8'h08, 32'd10, "abort_p0");
    rd_chk(0, 8'h0C, 32'd0, "abort_p1");

    // reset in the middle of an operation
    wr(0, 8'h00, 32'h77);
    wr(0, 8'h04, 32'h55);
    repeat (5) tick();
    wb_rst_i = 1'b1;
    #1;
    chk("midrst_ack", {63'd0, ack_v[0]}, 64'd0);
    chk("midrst_irq", {61'd0, irq_v[0]}, 64'd0);
    tick();
    wb_rst_i = 1'b0;
    irq_seen = 0;
    for (int i = 0; i < lat_of(0) + 5; i++) begin
      irq_seen |= int'(irq_v[0][0]);
      tick();
    end
    chk("midrst_irq_stays_low", 64'(irq_seen), 64'd0);
    rd_chk(0, 8'h14, 32'd0, "midrst_status");
    rd_chk(0, 8'h08, 32'd0, "midrst_p0");
    rd_chk(0, 8'h0C, 32'd0, "midrst_p1");

    // narrow parameterisations, including stored-but-ignored upper bits
    run_op(1, 1'b1, 32'h80, 32'h7F, "w8_s_min_x_max");
    run_op(1, 1'b1, 32'hABCDEF80, 32'h1234567F, "w8_hibits");
    run_op(2, 1'b1, 32'h8000, 32'h8000, "w16_s_minxmin");

    // random operands against the reference model
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 6; k++) begin
        mc = $urandom;
        mp = $urandom;
        s  = 1'($urandom_range(0, 1));
        run_op(d, s, mc, mp, $sformatf("rnd_d%0d_%0d", d, k));
      end
    end

    e = ref_p(8, 1'b1, 32'h80, 32'h7F);
    chk("model_sanity_w8", e, 64'hFFFFFFFFFFFFC080);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_mul_iter_periph.md
Name: wb_mul_iter_periph

Overview:
Parametrised Wishbone slave multiplier peripheral: generation-two of the team's WB multiplier block. It holds MC/MP operand registers, runs an iterative radix-2^BPC multiply engine and exposes a 2*OP_W product as two 32-bit words. It adds signed/unsigned mode, a status register, a sticky done flag and a maskable interrupt. It sits on the user-project Wishbone bus beside the other memory-mapped accelerators.

Parameters:
OP_W, 32, operand width in bits; legal values 8, 16, 32.
BPC, 1, multiplier bits retired per cycle; legal values 1, 2, 4; must divide OP_W.
BAD_DATA, 32'hDEADBEEF, read data returned for unmapped offsets.

Ports:
sys_clk  in  1  clock.
wb_rst_i  in  1  asynchronous active-high reset.
wbs_stb_i  in  1  WB strobe.
wbs_cyc_i  in  1  WB cycle.
wbs_we_i  in  1  WB write enable.
wbs_sel_i  in  4  WB byte selects.
wbs_dat_i  in  32  WB write data.
wbs_adr_i  in  32  WB address; only [7:0] decoded.
wbs_ack_o  out  1  WB acknowledge (registered).
wbs_dat_o  out  32  WB read data.
irq  out  3  irq[0] = done interrupt; irq[2:1] tied 0.

Behaviour:
- Reset wb_rst_i is asynchronous and active-high; clock is sys_clk. Reset values: MC=0, MP=0, CTRL=0, P=0, busy=0, done=0, wbs_ack_o=0, irq=0.
- Register map (byte offsets):
  - 0x00 MC (RW).
  - 0x04 MP (RW); a write starts an operation.
  - 0x08 P0 = P[31:0] (RO).
  - 0x0C P1 = P[63:32] (RO).
  - 0x10 CTRL (RW): bit0 signed, bit1 irq_en; other bits read 0.
  - 0x14 STATUS: bit0 busy (RO), bit1 done (sticky, W1C); other bits read 0.
  - Any other offset: reads BAD_DATA, writes are acked and ignored.
- Register writes honour wbs_sel_i per byte. Operand bits above OP_W are stored and read back, but ignored by the engine.
- Handshake: valid = stb & cyc. Ack is a one-cycle registered pulse asserted in the cycle after valid is sampled. Ack is deasserted the following cycle even if valid stays high; a new ack requires a new beat, i.e. ack low for a cycle. No back-to-back acks to the same beat.
- Wait state: a read of P0/P1 while busy=1 is held (no ack) until the cycle after done is set, then acked with the new product. All other accesses ack in 1 cycle regardless of busy.
- wbs_dat_o is combinational from the address and is stable while ack is high.
- Start: on the accepting edge of an MP write, the engine latches MC[OP_W-1:0], the new MP value and CTRL.signed. At the same edge busy is set, done is cleared and P is held (not cleared).
  - MC or CTRL writes during busy update the registers only; the running operation is unaffected.
  - An MP write during busy aborts the current operation and restarts with the new operands; no done or irq is raised for the aborted operation.
- Engine latency: LAT = OP_W/BPC + 2 cycles from the accepting edge to the edge that loads P, sets done and clears busy. The two extra cycles are operand conditioning and sign fix-up.
- Arithmetic:
  - Unsigned: P = zero-extended {MC*MP} over 2*OP_W bits, zero-extended to 64.
  - Signed: operands are two's complement; P is the exact 2*OP_W-bit product, sign-extended to 64. Implementation is magnitude multiply plus conditional negate.
  - Product of -2^(OP_W-1) * -2^(OP_W-1) = +2^(2*OP_W-2), exact.
- done stays set until an STATUS write with bit1=1 or the next start. If a W1C and a completion hit the same edge, completion wins (done=1).
- irq[0] = done & CTRL.irq_en, level.
- Reset mid-operation: the engine returns to idle immediately; no done, and any pending ack is dropped.

Decomposition:
- Package wb_mul_pkg: register offset localparams (MC, MP, P0, P1, CTRL, STATUS), CTRL/STATUS bit indices, BAD_DATA default, engine state enum (IDLE, PREP, ITER, FIX).
- Sub-module mul_iter_core: ports start, sgn, a, b, busy, done pulse, p[2*OP_W-1:0].
  - Parameters OP_W and BPC.
  - FSM: IDLE -> PREP (1 cycle: magnitudes and result sign) -> ITER (OP_W/BPC cycles, shift-add by BPC bits) -> FIX (1 cycle: negate, done) -> IDLE.
  - start in any state re-enters PREP.
- The top module holds the WB decode, registers, ack/wait logic and irq.

Test Plan:
- OP_W=32, BPC=1, unsigned: MC=7, MP=6 -> after LAT=34 cycles STATUS=0x2, P0=42, P1=0. Also MC=MP=0xFFFFFFFF -> P1=0xFFFFFFFE, P0=0x00000001.
- Signed (CTRL=1): MC=0xFFFFFFFB (-5), MP=3 -> P1=0xFFFFFFFF, P0=0xFFFFFFF1. Also MC=MP=0x80000000 -> P1=0x40000000, P0=0.
- Read P0 on the cycle after the MP write ack -> ack withheld until the cycle after done, then returns the new product; exactly one ack for the beat.
- MP write at cycle 10 of an operation with new MP=2, MC=5 -> no done from the first operation; done exactly LAT after the second write, P0=10.
- CTRL=0x2, complete an op -> irq[0]=1. Write STATUS=0x2 -> irq[0]=0 the cycle after the ack. Assert wb_rst_i mid-operation -> busy=0, P=0, no irq.
- Parameter sweep OP_W=8/16, BPC=2/4, signed MC=0x80 (OP_W=8), MP=0x7F -> P = 64-bit sign-extended -16256 (P1=0xFFFFFFFF, P0=0xFFFFC080), LAT = OP_W/BPC + 2.
